// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer:
// state encoding, IR field positions, word size and a popcount helper.
package ldm_stm_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_REQ    = 3'd2,
    ST_LOADWR = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam int IR_P       = 24;
  localparam int IR_U       = 23;
  localparam int IR_W       = 21;
  localparam int IR_L       = 20;
  localparam int IR_RN_LO   = 16;
  localparam int WORD_BYTES = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Bus between the control unit (master) and the LDM/STM sequencer (slave),
// including a debug view of the sequencer state.
interface ldm_stm_sequencer_if
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) ();
  logic              start;
  logic [31:0]       IR;
  logic [ADDR_W-1:0] base_value;
  logic              MOC;
  logic              busy;
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        reg_num;
  logic              reg_we;
  logic              wb_en;
  logic [3:0]        wb_num;
  logic [ADDR_W-1:0] wb_value;
  logic              done;
  state_t            dbg_state;

  // Memory handshake: mem_req/mem_rw/mem_addr stay stable from the first
  // cycle of a request until the edge that samples MOC high; that edge
  // completes the transfer. MOC seen while mem_req is low has no effect.
  modport master (
    output start, IR, base_value, MOC,
    input  busy, mem_req, mem_rw, mem_addr, reg_num, reg_we,
    input  wb_en, wb_num, wb_value, done, dbg_state
  );

  modport slave (
    input  start, IR, base_value, MOC,
    output busy, mem_req, mem_rw, mem_addr, reg_num, reg_we,
    output wb_en, wb_num, wb_value, done, dbg_state
  );
endinterface

// File: rtl/ldm_stm_sequencer_reg_list_scanner.sv
// Lowest-set-bit encoder for a 16-bit register list: index, any-set flag,
// and the list with that bit cleared.
module reg_list_scanner (
  input  logic [15:0] i_mask,
  output logic [3:0]  o_idx,
  output logic        o_valid,
  output logic [15:0] o_rest
);
  always_comb begin
    o_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (i_mask[i]) o_idx = 4'(i);
    end
    o_valid = |i_mask;
    o_rest  = i_mask & (i_mask - 16'd1);
  end
endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list lowest-first, issues one memory
// request per register, then reports base writeback and a done pulse.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic                clk,
  input logic                reset,
  ldm_stm_sequencer_if.slave bus
);
  state_t            r_state;
  logic              r_p, r_u, r_w, r_l;
  logic [15:0]       r_list;
  // Bits still to transfer after the one currently in r_reg_num.
  logic [15:0]       r_mask;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy, r_mem_req, r_mem_rw, r_reg_we;
  logic              r_wb_en, r_done;
  logic [3:0]        r_reg_num, r_wb_num;
  logic [ADDR_W-1:0] r_wb_value;

  logic [3:0]        w_scan_idx;
  logic              w_scan_vld;
  logic [15:0]       w_scan_rest;
  logic [4:0]        w_n;
  logic [ADDR_W-1:0] w_four_n, w_word, w_start_addr, w_wb_value;
  logic              w_advance, w_step;

  reg_list_scanner u_scan (
    .i_mask  (r_mask),
    .o_idx   (w_scan_idx),
    .o_valid (w_scan_vld),
    .o_rest  (w_scan_rest)
  );

  assign w_n        = popcount16(r_list);
  assign w_four_n   = ADDR_W'({w_n, 2'b00});
  assign w_word     = ADDR_W'(WORD_BYTES);
  assign w_wb_value = r_u ? (r_base + w_four_n) : (r_base - w_four_n);

  always_comb begin
    w_start_addr = r_base;
    case ({r_p, r_u})
      2'b01:   w_start_addr = r_base;
      2'b11:   w_start_addr = r_base + w_word;
      2'b00:   w_start_addr = r_base - w_four_n + w_word;
      default: w_start_addr = r_base - w_four_n;
    endcase
  end

  assign w_advance = (r_state == ST_LOADWR) ||
                     ((r_state == ST_REQ) && bus.MOC && !r_l);
  assign w_step    = (r_state == ST_SETUP) || w_advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      {r_p, r_u, r_w, r_l} <= 4'b0000;
      r_list     <= '0;
      r_mask     <= '0;
      r_base     <= '0;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_rw   <= 1'b0;
      r_reg_we   <= 1'b0;
      r_wb_en    <= 1'b0;
      r_done     <= 1'b0;
      r_reg_num  <= '0;
      r_wb_num   <= '0;
      r_wb_value <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_p      <= bus.IR[IR_P];
            r_u      <= bus.IR[IR_U];
            r_w      <= bus.IR[IR_W];
            r_l      <= bus.IR[IR_L];
            r_wb_num <= bus.IR[IR_RN_LO +: 4];
            r_list   <= bus.IR[15:0];
            r_mask   <= bus.IR[15:0];
            r_base   <= bus.base_value;
            r_busy   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_addr     <= w_start_addr & ~ADDR_W'(3);
          r_wb_value <= w_wb_value;
        end
        ST_REQ: begin
          if (bus.MOC) begin
            r_mem_req <= 1'b0;
            if (r_l) begin
              r_reg_we <= 1'b1;
              r_state  <= ST_LOADWR;
            end else begin
              r_addr <= r_addr + w_word;
            end
          end
        end
        ST_LOADWR: begin
          r_reg_we <= 1'b0;
          r_addr   <= r_addr + w_word;
        end
        ST_FINISH: begin
          r_done  <= 1'b0;
          r_wb_en <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Shared exit from SETUP / a completed transfer: next register or finish.
      if (w_step) begin
        if (w_scan_vld) begin
          r_reg_num <= w_scan_idx;
          r_mask    <= w_scan_rest;
          r_mem_req <= 1'b1;
          r_mem_rw  <= r_l;
          r_state   <= ST_REQ;
        end else begin
          r_mem_req <= 1'b0;
          r_mem_rw  <= 1'b0;
          r_done    <= 1'b1;
          r_wb_en   <= r_w && (r_list != 16'd0) && !(r_l && r_list[r_wb_num]);
          r_state   <= ST_FINISH;
        end
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_rw    = r_mem_rw;
  assign bus.mem_addr  = r_addr;
  assign bus.reg_num   = r_reg_num;
  assign bus.reg_we    = r_reg_we;
  assign bus.wb_en     = r_wb_en;
  assign bus.wb_num    = r_wb_num;
  assign bus.wb_value  = r_wb_value;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: hand-computed access sequences,
// writeback values and completion timing for each addressing mode.
module tb_ldm_stm_sequencer;
  import ldm_stm_sequencer_pkg::*;

  localparam int W = 37;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_we_q[$];

  ldm_stm_sequencer_if #(.ADDR_W(32)) sif ();

  ldm_stm_sequencer #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic p, input logic u, input logic w,
                                        input logic l, input logic [3:0] rn,
                                        input logic [15:0] list);
    return {7'b1110100, p, u, 1'b0, w, l, rn, list};
  endfunction

  function automatic logic [W-1:0] acc(input logic rw, input logic [3:0] rnum,
                                       input logic [31:0] addr);
    return {rw, rnum, addr};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 40'({sif.busy, sif.mem_req, sif.mem_rw, sif.reg_we,
                              sif.wb_en, sif.done}), 40'd0);
    check({tag, "_addr"}, 40'(sif.mem_addr), 40'd0);
    check({tag, "_wbval"}, 40'(sif.wb_value), 40'd0);
    check({tag, "_nums"}, 40'({sif.reg_num, sif.wb_num}), 40'd0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; start is sampled at the next posedge (edge k), so
  // loop cycle 1 is SETUP and done must appear on cycle exp_done.
  task automatic do_op(input logic [31:0] ir, input logic [31:0] base, input int delay,
                       input logic restart, input int exp_done, input logic exp_wb_en,
                       input logic [3:0] exp_wb_num, input logic [31:0] exp_wb_val);
    int          cyc;
    int          waitc;
    int          done_cyc;
    logic        pend;
    logic [31:0] hold_addr;
    sif.IR         = ir;
    sif.base_value = base;
    sif.start      = 1'b1;
    sif.MOC        = (delay == 0);
    @(negedge clk);
    sif.start = 1'b0;
    cyc       = 1;
    waitc     = 0;
    done_cyc  = -1;
    pend      = 1'b0;
    hold_addr = '0;
    check("busy_setup", 40'(sif.busy), 40'd1);
    while (done_cyc < 0 && cyc <= 60) begin
      sif.start = restart && (cyc == 1);
      if (restart && cyc == 1) sif.IR = mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'hFFFF);
      if (pend) begin
        check("req_hold", 40'(sif.mem_req), 40'd1);
        check("addr_hold", 40'(sif.mem_addr), 40'(hold_addr));
      end
      pend = 1'b0;
      if (sif.mem_req) begin
        if (delay == 0 || waitc == delay) begin
          sif.MOC = 1'b1;
          waitc   = 0;
          if (exp_q.size() > 0)
            check("access", 40'(acc(sif.mem_rw, sif.reg_num, sif.mem_addr)), 40'(exp_q.pop_front()));
          else
            check("access_extra", 40'(sif.mem_addr), 40'hFF_FFFF_FFFF);
        end else begin
          sif.MOC   = 1'b0;
          waitc++;
          pend      = 1'b1;
          hold_addr = sif.mem_addr;
        end
      end else begin
        sif.MOC = (delay == 0);
      end
      if (sif.reg_we) begin
        if (exp_we_q.size() > 0) check("reg_we", 40'(sif.reg_num), 40'(exp_we_q.pop_front()));
        else check("reg_we_extra", 40'(sif.reg_num), 40'hFF);
      end
      if (sif.done) begin
        done_cyc = cyc;
        check("wb_en", 40'(sif.wb_en), 40'(exp_wb_en));
        check("wb_num", 40'(sif.wb_num), 40'(exp_wb_num));
        check("wb_value", 40'(sif.wb_value), 40'(exp_wb_val));
      end
      @(negedge clk);
      cyc++;
    end
    sif.start = 1'b0;
    sif.MOC   = 1'b0;
    check("done_cycle", 40'(done_cyc), 40'(exp_done));
    check("acc_left", 40'(exp_q.size()), 40'd0);
    check("we_left", 40'(exp_we_q.size()), 40'd0);
    check("busy_after", 40'(sif.busy), 40'd0);
    exp_q.delete();
    exp_we_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       bad;
    logic       seen;
    errors         = 0;
    checks         = 0;
    reset          = 1'b1;
    sif.start      = 1'b0;
    sif.IR         = '0;
    sif.base_value = '0;
    sif.MOC        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    check("reset_state", 40'(sif.dbg_state), 40'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // STMIA R4!, {R1-R3}
    exp_q.push_back(acc(1'b0, 4'd1, 32'h1000));
    exp_q.push_back(acc(1'b0, 4'd2, 32'h1004));
    exp_q.push_back(acc(1'b0, 4'd3, 32'h1008));
    do_op(mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 16'h000E), 32'h1000, 0, 1'b0,
          5, 1'b1, 4'd4, 32'h100C);

    // LDMDB R1!, {R0,R15}, started in the IDLE cycle right after FINISH
    exp_q.push_back(acc(1'b1, 4'd0, 32'h1FF8));
    exp_q.push_back(acc(1'b1, 4'd15, 32'h1FFC));
    exp_we_q.push_back(4'd0);
    exp_we_q.push_back(4'd15);
    do_op(mk_ir(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h8001), 32'h2000, 0, 1'b0,
          6, 1'b1, 4'd1, 32'h1FF8);

    // LDMIB R2!, {R2}: loaded base suppresses writeback
    exp_q.push_back(acc(1'b1, 4'd2, 32'h3004));
    exp_we_q.push_back(4'd2);
    do_op(mk_ir(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0004), 32'h3000, 0, 1'b0,
          4, 1'b0, 4'd2, 32'h3004);

    // STMDA R5!, {R0,R1}, MOC after 3 wait cycles; writeback wraps below zero
    exp_q.push_back(acc(1'b0, 4'd0, 32'h0000_0000));
    exp_q.push_back(acc(1'b0, 4'd1, 32'h0000_0004));
    do_op(mk_ir(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 16'h0003), 32'h0000_0004, 3, 1'b0,
          10, 1'b1, 4'd5, 32'hFFFF_FFFC);

    // Empty list with W=1, plus a second start during SETUP that must be ignored
    do_op(mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 16'h0000), 32'h5000, 0, 1'b1,
          2, 1'b0, 4'd6, 32'h5000);
    check("ignored_start", 40'({sif.busy, sif.mem_req}), 40'd0);

    // Reset while an LDMIA is waiting in REQ
    sif.IR         = mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 16'h00F0);
    sif.base_value = 32'h4000;
    sif.start      = 1'b1;
    sif.MOC        = 1'b0;
    @(negedge clk);
    sif.start = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = sif.mem_req;
    end
    check("mid_req", 40'(seen), 40'd1);
    check("mid_req_addr", 40'(sif.mem_addr), 40'h4000);
    reset = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    check("rst_mid_state", 40'(sif.dbg_state), 40'(ST_IDLE));
    reset = 1'b0;
    bad   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bad = bad | sif.done | sif.wb_en | sif.busy | sif.mem_req;
    end
    check("rst_quiet", 40'(bad), 40'd0);

    // Fresh LDMIA R0!, {R10,R11} after the reset
    exp_q.push_back(acc(1'b1, 4'd10, 32'h0100));
    exp_q.push_back(acc(1'b1, 4'd11, 32'h0104));
    exp_we_q.push_back(4'd10);
    exp_we_q.push_back(4'd11);
    do_op(mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'h0C00), 32'h0100, 0, 1'b0,
          6, 1'b1, 4'd0, 32'h0108);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
